// File: rtl/sram_bar_reader_pkg.sv
// Shared constants and bar layout for the SRAM bar reader/writer pair.
// Bar b occupies word addresses (b+1)*4 .. (b+1)*4+3, LS word first.
package sram_bar_reader_pkg;

  localparam int unsigned ADDR_W        = 20;
  localparam int unsigned WORD_W        = 16;
  localparam int unsigned BAR_W         = 3;
  localparam int unsigned NUM_BARS      = 8;
  localparam int unsigned WORDS_PER_BAR = 4;
  localparam int unsigned CNT_W         = 2;
  localparam int unsigned DATA_W        = WORD_W * WORDS_PER_BAR;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // First word address of a bar; addresses 0-3 are never used.
  function automatic logic [ADDR_W-1:0] bar_base(input logic [BAR_W-1:0] bar);
    return ADDR_W'({bar, 2'b00}) + ADDR_W'(WORDS_PER_BAR);
  endfunction

endpackage

// File: rtl/sram_bar_reader_if.sv
// Fetch-control and playback bus between the bar reader and its neighbours.
interface sram_bar_reader_if;
  import sram_bar_reader_pkg::*;

  logic                i_req;
  logic [BAR_W-1:0]    i_bar;
  logic                i_play;
  logic                i_tick;
  logic [WORD_W-1:0]   i_SRAM_DQ;
  logic [ADDR_W-1:0]   o_addr;
  logic [DATA_W-1:0]   o_music_data;
  logic                o_valid;
  logic                o_empty;
  logic [BAR_W-1:0]    o_bar;
  logic                o_busy;

  modport slave (
    input  i_req, i_bar, i_play, i_tick, i_SRAM_DQ,
    output o_addr, o_music_data, o_valid, o_empty, o_bar, o_busy
  );

  modport master (
    output i_req, i_bar, i_play, i_tick, i_SRAM_DQ,
    input  o_addr, o_music_data, o_valid, o_empty, o_bar, o_busy
  );

endinterface

// File: rtl/sram_bar_reader.sv
// Fetches one 4-word bar from SRAM on request or auto-play tick and
// presents it as a 64-bit word with a one-cycle valid pulse.
module sram_bar_reader
  import sram_bar_reader_pkg::*;
(
  input  logic              i_bclk,
  input  logic              i_rst,
  sram_bar_reader_if.slave  bus,
  output wire               o_oe_n
);

  logic [1:0]               r_state, w_state_nxt;
  logic [ADDR_W-1:0]        r_addr,  w_addr_nxt;
  logic [CNT_W-1:0]         r_cnt,   w_cnt_nxt;
  logic [DATA_W-WORD_W-1:0] r_shift, w_shift_nxt;
  logic [DATA_W-1:0]        r_data,  w_data_nxt;
  logic                     r_valid, w_valid_nxt;
  logic                     r_empty, w_empty_nxt;
  logic                     r_busy,  w_busy_nxt;
  logic                     r_pend,  w_pend_nxt;
  logic                     r_play_d;
  logic [BAR_W-1:0]         r_bar,   w_bar_nxt;
  logic [BAR_W-1:0]         r_cur,   w_cur_nxt;
  logic [BAR_W-1:0]         r_ptr,   w_ptr_nxt;
  logic                     w_serve;
  logic [DATA_W-1:0]        w_fetched;

  // Newest word arrives on the DQ pins; the three older ones sit in r_shift.
  assign w_fetched = {bus.i_SRAM_DQ, r_shift};

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_empty_nxt = r_empty;
    w_busy_nxt  = r_busy;
    w_bar_nxt   = r_bar;
    w_cur_nxt   = r_cur;
    w_ptr_nxt   = r_ptr;
    w_serve     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_req) begin
          w_cur_nxt   = bus.i_bar;
          w_addr_nxt  = bar_base(bus.i_bar);
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_READ;
        end else if (r_pend) begin
          w_serve     = 1'b1;
          w_cur_nxt   = r_ptr;
          w_addr_nxt  = bar_base(r_ptr);
          w_ptr_nxt   = r_ptr + BAR_W'(1);
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_READ;
        end
      end
      S_READ: begin
        if (r_cnt == CNT_W'(WORDS_PER_BAR - 1)) begin
          w_data_nxt  = w_fetched;
          w_empty_nxt = (w_fetched == '0);
          w_bar_nxt   = r_cur;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_shift_nxt = {bus.i_SRAM_DQ, r_shift[DATA_W-WORD_W-1:WORD_W]};
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // One-deep tick queue; a tick arriving while one is pending is dropped.
    w_pend_nxt = (r_pend & ~w_serve) | (bus.i_tick & bus.i_play & ~r_pend);
    if (r_play_d & ~bus.i_play) begin
      w_ptr_nxt  = '0;
      w_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_bclk or negedge i_rst) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_empty  <= 1'b0;
      r_busy   <= 1'b0;
      r_pend   <= 1'b0;
      r_play_d <= 1'b0;
      r_bar    <= '0;
      r_cur    <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_empty  <= w_empty_nxt;
      r_busy   <= w_busy_nxt;
      r_pend   <= w_pend_nxt;
      r_play_d <= bus.i_play;
      r_bar    <= w_bar_nxt;
      r_cur    <= w_cur_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  // Output enable is released onto the shared bus outside of READ.
  assign o_oe_n           = (r_state == S_READ) ? 1'b0 : 1'bz;
  assign bus.o_addr       = r_addr;
  assign bus.o_music_data = r_data;
  assign bus.o_valid      = r_valid;
  assign bus.o_empty      = r_empty;
  assign bus.o_bar        = r_bar;
  assign bus.o_busy       = r_busy;

endmodule
